// File: rtl/dff_share_arbiter.sv
// rtl/dff_share_arbiter.sv - round-robin arbiter owning one shared W-bit register, optional burst lock (DFF_ARB_LOCK_EN)
module dff_share_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int LOCK_MAX = 16,
    localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]       req_lock,
    output logic [N_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]       q,
    output logic                   q_valid,
    output logic [IDX_W-1:0]       q_owner,
    output logic                   lock_active
);

    localparam logic [IDX_W:0]   N_SUM = (IDX_W+1)'(N_REQ);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_REQ - 1);

    logic [WIDTH-1:0] q_q;
    logic             q_valid_q;
    logic [IDX_W-1:0] q_owner_q;
    logic [IDX_W-1:0] ptr_q;

    logic [N_REQ-1:0] ready_d;
    logic [IDX_W-1:0] win;
    logic             hs;
    logic [IDX_W:0]   scan_sum;
    logic [IDX_W-1:0] scan_idx;
    logic [WIDTH-1:0] wr_data;

`ifdef DFF_ARB_LOCK_EN
    localparam int             CNT_W   = $clog2(LOCK_MAX);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX - 1);

    typedef enum logic {ST_ARB, ST_LOCKED} state_t;

    state_t           state_q;
    logic [IDX_W-1:0] owner_q;
    logic [CNT_W-1:0] cnt_q;
    logic             lock_active_q;
`else
    // The lock input and its depth are part of the fixed interface only.
    logic unused_lock;
    assign unused_lock = (^req_lock) ^ LOCK_MAX[0];
`endif

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (i == LAST) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    // Pick the winner: locked owner, else first valid scanning upward from ptr with wrap.
    always_comb begin
        ready_d  = '0;
        win      = '0;
        hs       = 1'b0;
        scan_sum = '0;
        scan_idx = '0;
`ifdef DFF_ARB_LOCK_EN
        if (state_q == ST_LOCKED) begin
            win = owner_q;
            hs  = req_valid[owner_q];
        end else
`endif
        begin
            for (int k = 0; k < N_REQ; k++) begin
                scan_sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
                if (scan_sum >= N_SUM) begin
                    scan_sum = scan_sum - N_SUM;
                end
                scan_idx = scan_sum[IDX_W-1:0];
                if (!hs && req_valid[scan_idx]) begin
                    hs  = 1'b1;
                    win = scan_idx;
                end
            end
        end
        if (hs) begin
            ready_d[win] = 1'b1;
        end
    end

    // Writer data mux for the granted requester.
    always_comb begin
        wr_data = req_data[win*WIDTH +: WIDTH];
    end

    // Shared register, rotation pointer and lock sequencing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q           <= '0;
            q_valid_q     <= 1'b0;
            q_owner_q     <= '0;
            ptr_q         <= '0;
`ifdef DFF_ARB_LOCK_EN
            state_q       <= ST_ARB;
            owner_q       <= '0;
            cnt_q         <= '0;
            lock_active_q <= 1'b0;
`endif
        end else begin
            if (hs) begin
                q_q       <= wr_data;
                q_owner_q <= win;
                q_valid_q <= 1'b1;
            end
`ifdef DFF_ARB_LOCK_EN
            if (state_q == ST_LOCKED) begin
                cnt_q <= cnt_q + 1'b1;
                if (!req_lock[owner_q] || cnt_q == CNT_MAX) begin
                    state_q       <= ST_ARB;
                    lock_active_q <= 1'b0;
                    ptr_q         <= next_idx(owner_q);
                end
            end else if (hs) begin
                ptr_q <= next_idx(win);
                if (req_lock[win]) begin
                    state_q       <= ST_LOCKED;
                    owner_q       <= win;
                    cnt_q         <= '0;
                    lock_active_q <= 1'b1;
                end
            end
`else
            if (hs) begin
                ptr_q <= next_idx(win);
            end
`endif
        end
    end

    // Grants are forced low while reset is held.
    assign req_ready = reset_n ? ready_d : '0;
    assign q         = q_q;
    assign q_valid   = q_valid_q;
    assign q_owner   = q_owner_q;
`ifdef DFF_ARB_LOCK_EN
    assign lock_active = lock_active_q;
`else
    assign lock_active = 1'b0;
`endif

endmodule

// File: tb/tb_dff_share_arbiter.sv
// tb/tb_dff_share_arbiter.sv - directed self-checking bench for dff_share_arbiter
module tb_dff_share_arbiter;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_lock;
    logic [3:0]  req_ready;
    logic [7:0]  q;
    logic        q_valid;
    logic [1:0]  q_owner;
    logic        lock_active;

    int n_chk;
    int n_bad;

    dff_share_arbiter #(.N_REQ(4), .WIDTH(8), .LOCK_MAX(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_lock   (req_lock),
        .req_ready  (req_ready),
        .q          (q),
        .q_valid    (q_valid),
        .q_owner    (q_owner),
        .lock_active(lock_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [7:0] d);
        req_data[i*8 +: 8] = d;
    endtask

    initial begin
        int n_la;
        int n_wr;
        n_chk     = 0;
        n_bad     = 0;
        reset_n   = 1'b0;
        req_valid = 4'b1111;
        req_lock  = 4'b0000;
        req_data  = 32'h13121110;
        tick;
        tick;
        chk("rst_q", {24'd0, q}, 32'h0);
        chk("rst_qv", {31'd0, q_valid}, 32'd0);
        chk("rst_own", {30'd0, q_owner}, 32'd0);
        chk("rst_la", {31'd0, lock_active}, 32'd0);
        chk("rst_rdy", {28'd0, req_ready}, 32'd0);
        reset_n = 1'b1;

        // Full contention rotation; without locking hardware the lock requests are inert.
`ifndef DFF_ARB_LOCK_EN
        req_lock = 4'b1111;
`endif
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rot_rdy", {28'd0, req_ready}, 32'd1 << i);
            tick;
            chk("rot_q", {24'd0, q}, 32'h10 + i);
            chk("rot_own", {30'd0, q_owner}, i);
            chk("rot_qv", {31'd0, q_valid}, 32'd1);
            chk("rot_la", {31'd0, lock_active}, 32'd0);
        end
        req_lock = 4'b0000;

        // Move ptr to 2 via requester 1 alone, then check wrap to 0 then 1.
        req_data  = 32'h23222120;
        req_valid = 4'b0010;
        #1;
        chk("p2_rdy", {28'd0, req_ready}, 32'b0010);
        tick;
        req_valid = 4'b0011;
        #1;
        chk("wrap_rdy0", {28'd0, req_ready}, 32'b0001);
        tick;
        chk("wrap_q0", {24'd0, q}, 32'h20);
        #1;
        chk("wrap_rdy1", {28'd0, req_ready}, 32'b0010);
        tick;
        chk("wrap_q1", {24'd0, q}, 32'h21);
        chk("wrap_own1", {30'd0, q_owner}, 32'd1);

        // Idle: no grant, register holds.
        req_valid = 4'b0000;
        #1;
        chk("idle_rdy", {28'd0, req_ready}, 32'd0);
        tick;
        chk("idle_q", {24'd0, q}, 32'h21);

        // A lone requester is granted every cycle (ptr is 2 here).
        req_valid = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            set_data(2, 8'h30 + 8'(i));
            #1;
            chk("solo_rdy", {28'd0, req_ready}, 32'b0100);
            tick;
            chk("solo_q", {24'd0, q}, 32'h30 + i);
        end
        // ptr is now 3

`ifdef DFF_ARB_LOCK_EN
        // Requester 1 takes a lock and holds it past the limit.
        req_valid = 4'b0010;
        req_lock  = 4'b0010;
        set_data(1, 8'h3F);
        #1;
        chk("lk_first", {28'd0, req_ready}, 32'b0010);
        tick;
        req_valid = 4'b1111;
        n_la = 0;
        n_wr = 0;
        for (int k = 0; k < 16; k++) begin
            set_data(1, 8'h40 + 8'(k));
            #1;
            if (lock_active) n_la++;
            if (lock_active && req_ready == 4'b0010) n_wr++;
            tick;
        end
        chk("lk_cycles", n_la, 32'd16);
        chk("lk_writes", n_wr, 32'd16);
        chk("lk_q", {24'd0, q}, 32'h4F);
        chk("lk_off", {31'd0, lock_active}, 32'd0);
        chk("lk_next", {28'd0, req_ready}, 32'b0100);
        tick;
        chk("lk_own2", {30'd0, q_owner}, 32'd2);
        // ptr is now 3

        // Requester 3 locks then releases voluntarily after 3 cycles.
        req_lock  = 4'b1000;
        req_valid = 4'b1000;
        #1;
        chk("vl_first", {28'd0, req_ready}, 32'b1000);
        tick;
        req_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("vl_hold", {28'd0, req_ready}, 32'b1000);
            tick;
        end
        req_lock = 4'b0000;
        #1;
        chk("vl_last", {28'd0, req_ready}, 32'b1000);
        chk("vl_la", {31'd0, lock_active}, 32'd1);
        tick;
        chk("vl_off", {31'd0, lock_active}, 32'd0);
        chk("vl_ptr0", {28'd0, req_ready}, 32'b0001);

        // Requester 0 locks with A5 for the reset check.
        req_lock = 4'b0001;
        set_data(0, 8'hA5);
        tick;
        chk("mr_la", {31'd0, lock_active}, 32'd1);
`else
        req_valid = 4'b0001;
        set_data(0, 8'hA5);
        tick;
`endif
        chk("mr_q", {24'd0, q}, 32'hA5);

        // Asynchronous reset mid-cycle clears outputs at once.
        #2;
        reset_n   = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("ar_q", {24'd0, q}, 32'd0);
        chk("ar_qv", {31'd0, q_valid}, 32'd0);
        chk("ar_la", {31'd0, lock_active}, 32'd0);
        chk("ar_rdy", {28'd0, req_ready}, 32'd0);
        tick;
        chk("ar_rdy2", {28'd0, req_ready}, 32'd0);
        reset_n  = 1'b1;
        req_lock = 4'b0000;
        #1;
        chk("ar_first", {28'd0, req_ready}, 32'b0001);
        tick;
        chk("ar_own", {30'd0, q_owner}, 32'd0);
        chk("ar_q2", {24'd0, q}, 32'hA5);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/dff_share_arbiter.md
# dff_share_arbiter

Round-robin arbiter and sequencer for one shared W-bit D-type register bank (posedge-clocked storage with asynchronous clear). N requesters compete for write access through valid/ready handshakes; the block grants at most one writer per cycle and loads the winner's data into the shared register. A requester may lock the register for a bounded burst. The block sits between the requesting datapaths and the shared state, and is the only writer of that state.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2–16.
- `WIDTH`, default 8: width of the shared register.
- `LOCK_MAX`, default 16: maximum number of cycles one lock can be held; legal range 2–256.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in `N_REQ`: bit i set means requester i has a write pending.
- `req_data` in `N_REQ*WIDTH`: write data; requester i occupies bits `[i*WIDTH +: WIDTH]`.
- `req_lock` in `N_REQ`: bit i set means requester i asks to keep ownership after its grant.
- `req_ready` out `N_REQ`: one-hot or zero grant; a handshake is `req_valid[i] & req_ready[i]` at a rising edge.
- `q` out `WIDTH`: shared register contents.
- `q_valid` out 1: set after the first write since reset.
- `q_owner` out `$clog2(N_REQ)`: index of the last writer.
- `lock_active` out 1: high while in state LOCKED.

## Operation
- Reset values: `q`=0, `q_valid`=0, `q_owner`=0, `lock_active`=0. Internally, priority pointer `ptr`=0, state ARB, `lock_cnt`=0.
- State ARB: `req_ready` is combinational. It grants the first set `req_valid` bit found scanning upward from `ptr`, with wrap-around modulo `N_REQ`. If no bit is set, `req_ready`=0.
- On a handshake by requester i in ARB:
  - `q` ← `req_data[i]`, `q_owner` ← i, `q_valid` ← 1.
  - `ptr` ← (i+1) mod `N_REQ`.
  - If `req_lock[i]`=1, go to LOCKED with owner i and `lock_cnt`=0.
- State LOCKED:
  - `req_ready[owner]`=`req_valid[owner]`; all other ready bits are 0.
  - The owner may write on any cycle; each write updates `q`. `ptr` is not changed by writes in LOCKED.
  - `lock_cnt` increments every cycle, whether or not a write occurs.
- LOCKED → ARB at an edge when either `req_lock[owner]`=0 or `lock_cnt`=`LOCK_MAX-1`. On that transition `ptr` ← (owner+1) mod `N_REQ`.
- The owner is still granted in the releasing cycle if `req_valid[owner]`=1. Forced release and voluntary release behave identically.
- A requester deasserting `req_valid` without a handshake is legal; no state changes.
- `req_data` is sampled only on a handshake.

## Timing
- Grant is combinational: `req_ready` depends on `req_valid`, state, owner and `ptr`.
- Write latency is 1 cycle: `q` and `q_owner` show the new value right after the handshake edge.
- Maximum throughput is one write per cycle.
- A single requester asserting `req_valid` continuously, with no lock, is granted every cycle.
- Worst-case wait for requester i under full contention: `N_REQ-1` grants in ARB plus at most one lock of `LOCK_MAX` cycles per grant.
- When `reset_n` falls, all outputs clear immediately, mid-lock included. The first grant is possible in the first cycle after release with `ptr`=0.
- Simultaneous requests are resolved purely by `ptr` order.

## Configuration
- `DFF_ARB_LOCK_EN` defined: LOCKED state, `lock_cnt` and `lock_active` are present as described above.
- Not defined:
  - `req_lock` is ignored; the port remains for a fixed interface.
  - `lock_active` is tied to 0; the block is pure round-robin in ARB only.
  - `LOCK_MAX` is unused.

## Test plan
- Reset, then `req_valid`=4'b1111 for 4 cycles with `req_data` i = 8'h10+i: grants go 0,1,2,3, and `q` reads 10,11,12,13 one cycle after each grant.
- `ptr`=2 and `req_valid`=4'b0011: grant to 0, then to 1; verify wrap-around.
- With `DFF_ARB_LOCK_EN`: requester 1 holds `req_lock` and `req_valid` for 20 cycles while the others request. Required: `lock_active` for exactly 16 cycles, 16 writes from 1, then grant to 2.
- With `DFF_ARB_LOCK_EN`: requester 3 locks and drops `req_lock` after 3 cycles. Required: return to ARB with `ptr`=0, and requester 0 granted next.
- Assert `reset_n`=0 mid-lock with `q`=8'hA5: `q`=0, `q_valid`=0 and `lock_active`=0 immediately, and `req_ready`=0 during reset.
- Without the macro: `req_lock`=1111 has no effect and rotation is identical to the first scenario.
